// File: rtl/rv32i_hazard_scoreboard.sv
// rv32i_hazard_scoreboard
// Hazard and forwarding controller for the pipelined RV32I core. Tracks the
// in-flight instructions after decode (entry 0 = E, entry PIPE_DEPTH-1 = W),
// produces E-stage forward selects, load-use stalls and redirect flushes.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush counters.
module rv32i_hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int PIPE_DEPTH   = 3,
  parameter int LOAD_LATENCY = 1,
  localparam int FWD_W       = $clog2(PIPE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  valid_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  uses_rs1_d,
  input  logic                  uses_rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic                  is_load_d,
  input  logic                  pc_src_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [FWD_W-1:0]      fwd_a_e,
`ifdef HAZARD_PERF_EN
  output logic [FWD_W-1:0]      fwd_b_e,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`else
  output logic [FWD_W-1:0]      fwd_b_e
`endif
);

  logic                  valid_q [PIPE_DEPTH];
  logic                  load_q  [PIPE_DEPTH];
  logic                  use1_q  [PIPE_DEPTH];
  logic                  use2_q  [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] rd_q    [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] rs1_q   [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] rs2_q   [PIPE_DEPTH];

  logic             load_use;
  logic [FWD_W-1:0] fwd_a_raw;
  logic [FWD_W-1:0] fwd_b_raw;
  logic             found_a;
  logic             found_b;
  logic             bubble;

  // Hazard detection and youngest-producer search over the scoreboard.
  // A load only becomes a forwarding source once its data is available;
  // before that the load-use stall keeps a consumer out of E.
  always_comb begin
    load_use  = 1'b0;
    fwd_a_raw = '0;
    fwd_b_raw = '0;
    found_a   = 1'b0;
    found_b   = 1'b0;
    for (int j = 0; j < LOAD_LATENCY; j++) begin
      if (valid_q[j] && load_q[j] && valid_d) begin
        if ((uses_rs1_d && rs1_d == rd_q[j]) || (uses_rs2_d && rs2_d == rd_q[j]))
          load_use = 1'b1;
      end
    end
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      if (valid_q[k] && (!load_q[k] || k >= 1 + LOAD_LATENCY)) begin
        if (!found_a && use1_q[0] && rd_q[k] == rs1_q[0]) begin
          fwd_a_raw = FWD_W'(k);
          found_a   = 1'b1;
        end
        if (!found_b && use2_q[0] && rd_q[k] == rs2_q[0]) begin
          fwd_b_raw = FWD_W'(k);
          found_b   = 1'b1;
        end
      end
    end
  end

  // Output control: frozen pipeline drives nothing, a redirect kills the
  // wrong-path D instruction and so overrides any load-use stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a_e = '0;
    fwd_b_e = '0;
    if (ena) begin
      fwd_a_e = fwd_a_raw;
      fwd_b_e = fwd_b_raw;
      if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign bubble = stall_d | flush_e;

  // Scoreboard shift: entries age by one stage per enabled clock, entry 0
  // captures D or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        load_q[k]  <= 1'b0;
        use1_q[k]  <= 1'b0;
        use2_q[k]  <= 1'b0;
        rd_q[k]    <= '0;
        rs1_q[k]   <= '0;
        rs2_q[k]   <= '0;
      end
    end else if (ena) begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        valid_q[k] <= valid_q[k-1];
        load_q[k]  <= load_q[k-1];
        use1_q[k]  <= use1_q[k-1];
        use2_q[k]  <= use2_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        rs1_q[k]   <= rs1_q[k-1];
        rs2_q[k]   <= rs2_q[k-1];
      end
      valid_q[0] <= !bubble && valid_d && reg_write_d && (rd_d != '0);
      load_q[0]  <= !bubble && valid_d && is_load_d;
      use1_q[0]  <= !bubble && valid_d && uses_rs1_d;
      use2_q[0]  <= !bubble && valid_d && uses_rs2_d;
      rd_q[0]    <= rd_d;
      rs1_q[0]   <= rs1_d;
      rs2_q[0]   <= rs2_d;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters for load-use stalls and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (ena) begin
      if (stall_d && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
      if (pc_src_e && flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// Directed bench for rv32i_hazard_scoreboard: DUT a uses the default
// parameters, DUT b uses PIPE_DEPTH=5 / LOAD_LATENCY=3; both share stimulus.
module tb_rv32i_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst, ena, valid_d, uses_rs1_d, uses_rs2_d, reg_write_d, is_load_d, pc_src_e;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       sf_a, sd_a, fd_a, fe_a;
  logic [1:0] fa_a, fb_a;
  logic       sf_b, sd_b, fd_b, fe_b;
  logic [2:0] fa_b, fb_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32i_hazard_scoreboard dut_a (
    .clk(clk), .rst(rst), .ena(ena), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .is_load_d(is_load_d), .pc_src_e(pc_src_e), .stall_f(sf_a), .stall_d(sd_a),
    .flush_d(fd_a), .flush_e(fe_a), .fwd_a_e(fa_a),
`ifdef HAZARD_PERF_EN
    .fwd_b_e(fb_a), .stall_count(sc_a), .flush_count(fc_a)
`else
    .fwd_b_e(fb_a)
`endif
  );

  rv32i_hazard_scoreboard #(.PIPE_DEPTH(5), .LOAD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .is_load_d(is_load_d), .pc_src_e(pc_src_e), .stall_f(sf_b), .stall_d(sd_b),
    .flush_d(fd_b), .flush_e(fe_b), .fwd_a_e(fa_b),
`ifdef HAZARD_PERF_EN
    .fwd_b_e(fb_b), .stall_count(sc_b), .flush_count(fc_b)
`else
    .fwd_b_e(fb_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the D-stage fields, then let combinational outputs settle.
  task automatic drv(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
    valid_d = v; rs1_d = r1; uses_rs1_d = u1; rs2_d = r2; uses_rs2_d = u2;
    rd_d = rd; reg_write_d = rw; is_load_d = ld;
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1; ena = 1; pc_src_e = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({sf_a, sd_a, fd_a, fe_a, fa_a, fb_a} !== 8'h00) begin
        failures++; $display("FAIL reset_idle_a cycle=%0d got=%h exp=00", i, {sf_a, sd_a, fd_a, fe_a, fa_a, fb_a});
      end
      checks++;
      if ({sf_b, sd_b, fd_b, fe_b, fa_b, fb_b} !== 10'h000) begin
        failures++; $display("FAIL reset_idle_b cycle=%0d got=%h exp=000", i, {sf_b, sd_b, fd_b, fe_b, fa_b, fb_b});
      end
      tick();
    end
  endtask

  task automatic test_forward();
    idle(5);
    drv(1, 0, 0, 0, 0, 5, 1, 0);            // add x5
    tick();
    drv(1, 5, 1, 0, 0, 7, 1, 0);            // add x7, x5
    checks++;
    if (sd_a !== 1'b0) begin failures++; $display("FAIL fwd1_nostall got=%b exp=0", sd_a); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fa_a, fb_a} !== 4'b0100) begin failures++; $display("FAIL fwd_dist1 got=%b exp=0100", {fa_a, fb_a}); end
    idle(4);
    drv(1, 0, 0, 0, 0, 8, 1, 0);            // add x8
    tick();
    idle(1);                                 // one-instruction gap
    drv(1, 8, 1, 0, 0, 9, 1, 0);            // consumer of x8
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (fa_a !== 2'd2) begin failures++; $display("FAIL fwd_dist2 got=%0d exp=2", fa_a); end
    idle(4);
    drv(1, 0, 0, 0, 0, 9, 1, 0);            // older x9
    tick();
    drv(1, 0, 0, 0, 0, 9, 1, 0);            // younger x9
    tick();
    drv(1, 9, 1, 9, 1, 10, 1, 0);           // reads x9 twice
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fa_a, fb_a} !== 4'b0101) begin failures++; $display("FAIL fwd_youngest got=%b exp=0101", {fa_a, fb_a}); end
  endtask

  task automatic test_load_use();
    idle(5);
    drv(1, 0, 0, 0, 0, 6, 1, 1);            // lw x6
    tick();
    drv(1, 0, 0, 6, 1, 10, 1, 0);           // reads x6 via rs2
    checks++;
    if ({sf_a, sd_a, fd_a, fe_a} !== 4'b1101) begin failures++; $display("FAIL lu_stall got=%b exp=1101", {sf_a, sd_a, fd_a, fe_a}); end
    tick();
    checks++;
    if ({sf_a, sd_a, fd_a, fe_a} !== 4'b0000) begin failures++; $display("FAIL lu_stall_len got=%b exp=0000", {sf_a, sd_a, fd_a, fe_a}); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fa_a, fb_a} !== 4'b0010) begin failures++; $display("FAIL lu_fwd got=%b exp=0010", {fa_a, fb_a}); end
  endtask

  task automatic test_load_use_ll3();
    idle(6);
    drv(1, 0, 0, 0, 0, 6, 1, 1);            // lw x6
    tick();
    drv(1, 0, 0, 6, 1, 10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sf_b, sd_b, fd_b, fe_b} !== 4'b1101) begin failures++; $display("FAIL ll3_stall cycle=%0d got=%b exp=1101", i, {sf_b, sd_b, fd_b, fe_b}); end
      tick();
    end
    checks++;
    if ({sf_b, sd_b, fd_b, fe_b} !== 4'b0000) begin failures++; $display("FAIL ll3_stall_len got=%b exp=0000", {sf_b, sd_b, fd_b, fe_b}); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fa_b, fb_b} !== 6'o04) begin failures++; $display("FAIL ll3_fwd got=%0d/%0d exp=0/4", fa_b, fb_b); end
  endtask

  task automatic test_redirect();
    idle(5);
    drv(1, 0, 0, 0, 0, 6, 1, 1);            // lw x6
    tick();
    pc_src_e = 1;
    drv(1, 0, 0, 6, 1, 11, 1, 1);           // lw x11 reading x6, wrong path
    checks++;
    if ({sf_a, sd_a, fd_a, fe_a} !== 4'b0011) begin failures++; $display("FAIL redirect_over_stall got=%b exp=0011", {sf_a, sd_a, fd_a, fe_a}); end
    tick();
    pc_src_e = 0;
    drv(1, 11, 1, 0, 0, 12, 1, 0);          // would stall if lw x11 had entered E
    checks++;
    if ({sf_a, sd_a, fd_a, fe_a} !== 4'b0000) begin failures++; $display("FAIL redirect_bubble got=%b exp=0000", {sf_a, sd_a, fd_a, fe_a}); end
  endtask

  task automatic test_x0_unused();
    idle(5);
    drv(1, 0, 0, 0, 0, 0, 1, 1);            // lw x0
    tick();
    drv(1, 0, 1, 0, 1, 12, 1, 0);           // reads x0 twice
    checks++;
    if (sd_a !== 1'b0) begin failures++; $display("FAIL x0_nostall got=%b exp=0", sd_a); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fa_a, fb_a} !== 4'b0000) begin failures++; $display("FAIL x0_nofwd got=%b exp=0000", {fa_a, fb_a}); end
    idle(4);
    drv(1, 0, 0, 0, 0, 13, 1, 1);           // lw x13
    tick();
    drv(1, 13, 0, 13, 0, 14, 1, 0);         // names x13 but does not read it
    checks++;
    if (sd_a !== 1'b0) begin failures++; $display("FAIL unused_nostall got=%b exp=0", sd_a); end
    tick();
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fa_a, fb_a} !== 4'b0000) begin failures++; $display("FAIL unused_nofwd got=%b exp=0000", {fa_a, fb_a}); end
  endtask

  task automatic test_freeze();
    idle(5);
    drv(1, 0, 0, 0, 0, 6, 1, 1);            // lw x6
    tick();
    drv(1, 0, 0, 6, 1, 10, 1, 0);
    checks++;
    if ({sf_a, sd_a, fd_a, fe_a} !== 4'b1101) begin failures++; $display("FAIL pre_freeze got=%b exp=1101", {sf_a, sd_a, fd_a, fe_a}); end
    ena = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({sf_a, sd_a, fd_a, fe_a, fa_a, fb_a} !== 8'h00) begin failures++; $display("FAIL frozen cycle=%0d got=%h exp=00", i, {sf_a, sd_a, fd_a, fe_a, fa_a, fb_a}); end
      tick();
    end
    ena = 1;
    #1;
    checks++;
    if ({sf_a, sd_a, fd_a, fe_a} !== 4'b1101) begin failures++; $display("FAIL resumed_stall got=%b exp=1101", {sf_a, sd_a, fd_a, fe_a}); end
    tick();
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (fb_a !== 2'd2) begin failures++; $display("FAIL post_freeze_fwd got=%0d exp=2", fb_a); end
    ena = 0;
    tick(); tick();
    checks++;
    if (fb_a !== 2'd0) begin failures++; $display("FAIL frozen_fwd got=%0d exp=0", fb_a); end
    ena = 1;
    #1;
    checks++;
    if (fb_a !== 2'd2) begin failures++; $display("FAIL resumed_fwd got=%0d exp=2", fb_a); end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst = 1;
    idle(1);
    rst = 0;
    idle(4);
    for (int n = 0; n < 2; n++) begin
      drv(1, 0, 0, 0, 0, 6, 1, 1);
      tick();
      drv(1, 0, 0, 6, 1, 10, 1, 0);
      tick(); tick();
      idle(4);
    end
    pc_src_e = 1;
    idle(3);
    pc_src_e = 0;
    idle(1);
    checks++;
    if (sc_a !== 32'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", sc_a); end
    checks++;
    if (fc_a !== 32'd3) begin failures++; $display("FAIL flush_count got=%0d exp=3", fc_a); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if ({sc_a, fc_a} !== 64'd0) begin failures++; $display("FAIL count_reset got=%0d/%0d exp=0/0", sc_a, fc_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_load_use_ll3();
    test_redirect();
    test_x0_unused();
    test_freeze();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
